// File: rtl/sonuc_toplayici.sv
// Result collector: buffers ALU results in a circular FIFO toward the register file and sequences JAL/JALR redirects.
// Optional macro SONUC_YONLENDIRME_EN exposes the youngest buffered result on the bypass_* ports.
module sonuc_toplayici #(
  parameter int FIFO_DERINLIK = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        amb_hazir_i,
  input  logic [31:0] amb_sonuc_i,
  input  logic [4:0]  hedef_yazmac_i,
  input  logic [31:0] jal_r_adres_i,
  input  logic        jal_r_adres_gecerli_i,
  output logic        yaz_gecerli_o,
  output logic [4:0]  yaz_adres_o,
  output logic [31:0] yaz_veri_o,
  input  logic        yaz_hazir_i,
  output logic        durdur_o,
  output logic [4:0]  doluluk_o,
  output logic        tasma_o,
  output logic        pc_yonlendir_o,
  output logic [31:0] pc_adres_o,
  output logic        temizle_o,
  output logic        bypass_gecerli_o,
  output logic [4:0]  bypass_adres_o,
  output logic [31:0] bypass_veri_o
);

  localparam int         PW       = $clog2(FIFO_DERINLIK);
  localparam logic [4:0] DERINLIK = 5'(FIFO_DERINLIK);
  localparam logic [4:0] ESIK     = 5'(FIFO_DERINLIK - 1);

  localparam logic [1:0] BOSTA     = 2'd0;
  localparam logic [1:0] YONLENDIR = 2'd1;
  localparam logic [1:0] TEMIZLE   = 2'd2;

  logic [36:0]   tampon [FIFO_DERINLIK];
  logic [PW-1:0] oku_ptr;
  logic [PW-1:0] yaz_ptr;
  logic [4:0]    doluluk;
  logic [4:0]    doluluk_sonraki;
  logic          itme_istek;
  logic          itme;
  logic          cekme;
  logic          dolu;

  assign itme_istek = amb_hazir_i && (hedef_yazmac_i != 5'd0);
  assign dolu       = (doluluk == DERINLIK);
  assign cekme      = (doluluk != 5'd0) && yaz_hazir_i;
  // A pop in the same cycle frees the head slot, so a push into a full buffer is still accepted.
  assign itme       = itme_istek && (!dolu || cekme);

  always_comb begin
    doluluk_sonraki = doluluk;
    if (itme && !cekme) begin
      doluluk_sonraki = doluluk + 5'd1;
    end else if (cekme && !itme) begin
      doluluk_sonraki = doluluk - 5'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      oku_ptr  <= '0;
      yaz_ptr  <= '0;
      doluluk  <= 5'd0;
      durdur_o <= 1'b0;
      tasma_o  <= 1'b0;
    end else begin
      if (itme) begin
        yaz_ptr <= yaz_ptr + PW'(1);
      end
      if (cekme) begin
        oku_ptr <= oku_ptr + PW'(1);
      end
      doluluk  <= doluluk_sonraki;
      // Stall one entry early so the result already in flight always has a slot.
      durdur_o <= (doluluk_sonraki >= ESIK);
      if (itme_istek && dolu && !cekme) begin
        tasma_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (itme) begin
      tampon[yaz_ptr] <= {hedef_yazmac_i, amb_sonuc_i};
    end
  end

  assign yaz_gecerli_o = (doluluk != 5'd0);
  assign yaz_adres_o   = yaz_gecerli_o ? tampon[oku_ptr][36:32] : 5'd0;
  assign yaz_veri_o    = yaz_gecerli_o ? tampon[oku_ptr][31:0]  : 32'd0;
  assign doluluk_o     = doluluk;

  logic [1:0]  durum;
  logic [31:0] hedef_adres;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      durum <= BOSTA;
    end else begin
      case (durum)
        BOSTA:     if (jal_r_adres_gecerli_i) durum <= YONLENDIR;
        YONLENDIR: durum <= TEMIZLE;
        default:   durum <= BOSTA;
      endcase
    end
  end

  // Targets arriving while a redirect is already in progress are wrong-path and ignored.
  always_ff @(posedge clk_i) begin
    if ((durum == BOSTA) && jal_r_adres_gecerli_i) begin
      hedef_adres <= jal_r_adres_i;
    end
  end

  assign pc_yonlendir_o = (durum == YONLENDIR);
  assign pc_adres_o     = pc_yonlendir_o ? hedef_adres : 32'd0;
  assign temizle_o      = (durum == TEMIZLE);

`ifdef SONUC_YONLENDIRME_EN
  logic        byp_gecerli;
  logic [4:0]  byp_adres;
  logic [31:0] byp_veri;

  // The youngest push is always the tail, so it is gone exactly when the buffer empties.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      byp_gecerli <= 1'b0;
    end else begin
      byp_gecerli <= (doluluk_sonraki != 5'd0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (itme) begin
      byp_adres <= hedef_yazmac_i;
      byp_veri  <= amb_sonuc_i;
    end
  end

  assign bypass_gecerli_o = byp_gecerli;
  assign bypass_adres_o   = byp_gecerli ? byp_adres : 5'd0;
  assign bypass_veri_o    = byp_gecerli ? byp_veri  : 32'd0;
`else
  assign bypass_gecerli_o = 1'b0;
  assign bypass_adres_o   = 5'd0;
  assign bypass_veri_o    = 32'd0;
`endif

endmodule

// File: doc/sonuc_toplayici.md
SONUC_TOPLAYICI -- requirements
Module: sonuc_toplayici

Interface
REQ-001 Parameter FIFO_DERINLIK, default 4, result-buffer depth in entries; legal values 2, 4, 8, 16.
REQ-002 clk_i  input  1  single clock; all state on rising edge.
REQ-003 rst_i  input  1  asynchronous, active-low reset.
REQ-004 amb_hazir_i  input  1  ALU result valid, one cycle per result.
REQ-005 amb_sonuc_i  input  32  ALU result, sampled with amb_hazir_i.
REQ-006 hedef_yazmac_i  input  5  destination register index, sampled with amb_hazir_i.
REQ-007 jal_r_adres_i  input  32  jump target from ALU.
REQ-008 jal_r_adres_gecerli_i  input  1  jump target valid.
REQ-009 yaz_gecerli_o  output  1  register-file write request.
REQ-010 yaz_adres_o  output  5  write register index.
REQ-011 yaz_veri_o  output  32  write data.
REQ-012 yaz_hazir_i  input  1  register file accepts the write this cycle.
REQ-013 durdur_o  output  1  stall request to ALU and issue logic.
REQ-014 doluluk_o  output  5  current buffer occupancy.
REQ-015 tasma_o  output  1  sticky overflow flag.
REQ-016 pc_yonlendir_o  output  1  one-cycle program-counter redirect pulse.
REQ-017 pc_adres_o  output  32  redirect target.
REQ-018 temizle_o  output  1  one-cycle fetch/decode flush pulse.
REQ-019 bypass_gecerli_o, bypass_adres_o, bypass_veri_o  output  1/5/32  youngest buffered result for operand forwarding.

Function
REQ-020 Buffer: circular FIFO of FIFO_DERINLIK entries {index[4:0], data[31:0]}; pointers wrap modulo depth.
REQ-021 Push: occurs when amb_hazir_i=1 and hedef_yazmac_i!=0; results for x0 are discarded and never pushed.
REQ-022 Pop: occurs when yaz_gecerli_o=1 and yaz_hazir_i=1.
REQ-023 yaz_gecerli_o = (occupancy!=0); yaz_adres_o/yaz_veri_o = head entry; zero when empty.
REQ-024 No fall-through: a push into an empty buffer raises yaz_gecerli_o in the following cycle.
REQ-025 Outputs shall hold stable while yaz_gecerli_o=1 and yaz_hazir_i=0.
REQ-026 Simultaneous push and pop: occupancy unchanged; this is legal even when full.
REQ-027 Stall: durdur_o = (occupancy >= FIFO_DERINLIK-1), registered from next-state occupancy, so one in-flight result always fits.
REQ-028 Overflow: push while full with no pop drops the result and sets tasma_o; tasma_o clears only on reset.
REQ-029 Redirect FSM states: BOSTA, YONLENDIR, TEMIZLE.
REQ-030 BOSTA -> YONLENDIR when jal_r_adres_gecerli_i=1; jal_r_adres_i is latched.
REQ-031 YONLENDIR: pc_yonlendir_o=1 and pc_adres_o=latched target for exactly one cycle, then -> TEMIZLE.
REQ-032 TEMIZLE: temizle_o=1 for exactly one cycle, then -> BOSTA.
REQ-033 jal_r_adres_gecerli_i shall be ignored outside BOSTA as wrong-path.
REQ-034 pc_adres_o shall be 0 outside YONLENDIR.
REQ-035 The redirect FSM and the buffer shall operate independently; the link-register result of a JAL/JALR is buffered normally.

Reset
REQ-036 rst_i=0 shall immediately clear pointers, occupancy, tasma_o, bypass state and FSM (to BOSTA), regardless of clk_i.
REQ-037 Every output shall be 0 during reset and in the first cycle after release.
REQ-038 Reset mid-operation shall discard buffered entries without issuing writes.

Configuration
REQ-039 Macro SONUC_YONLENDIRME_EN defined: bypass_* shall track the most recent push.
REQ-040 With the macro defined, bypass_gecerli_o shall clear when that entry pops or the buffer empties.
REQ-041 Macro undefined: bypass_* ports shall remain present and be tied to 0; all other behaviour is unchanged.

Verification
REQ-042 Push (x5, 0x1234) with yaz_hazir_i=1 -> next cycle yaz_gecerli_o=1, yaz_adres_o=5, yaz_veri_o=0x1234; buffer empty after one cycle.
REQ-043 amb_hazir_i=1 with hedef_yazmac_i=0, data 0xFFFF -> no write, doluluk_o stays 0.
REQ-044 Depth 4, yaz_hazir_i=0, four pushes -> durdur_o=1 after the third; a fifth push sets tasma_o=1, doluluk_o=4, and entries drain in order once yaz_hazir_i=1.
REQ-045 jal_r_adres_gecerli_i=1, target 0x80000100, held 3 cycles -> one pc_yonlendir_o pulse with pc_adres_o=0x80000100, then one temizle_o pulse, no second redirect.
REQ-046 Three entries buffered, rst_i pulsed low between clock edges -> outputs 0 at once, no writes issued, FSM in BOSTA.
